// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32i pipeline.
// Generates the hold/flush controls for the pipeline registers from three
// hazard sources: data-memory wait, Execute-stage mispredict, and load-use.
// A two-state FSM tracks outstanding memory accesses and enforces a timeout.
// Saturating counters record stall cycles and mispredict flushes.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  RUN      | no outstanding memory access; normal hazard handling
//  MEM_WAIT | memory access pending; whole pipeline frozen until ready/timeout
module hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RD_E,
    input  logic             REG_W_En_E,
    input  logic [1:0]       Result_Src_Sel_E,
    input  logic             Valid_E,
    input  logic             Mispredict_E,
    input  logic             MEM_Req_M,
    input  logic             MEM_Ready_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic             Mem_Fault,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Events
);

    // The wait counter must be able to hold MEM_TIMEOUT-1 even for MEM_TIMEOUT=1.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_fault;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_events;

    logic                w_mem_stall;
    logic                w_mispredict;
    logic                w_load_use;
    logic                w_stall_f;
    logic                w_stall_d;
    logic                w_stall_e;
    logic                w_stall_m;
    logic                w_flush_d;
    logic                w_flush_e;
    logic                w_flush_w;
    logic                w_mp_flush;

    // Raw hazard conditions, before priority is applied.
    always_comb begin
        w_mem_stall  = (r_state == RUN)      ? (MEM_Req_M && !MEM_Ready_M)
                                             : !MEM_Ready_M;
        w_mispredict = Mispredict_E && Valid_E;
        w_load_use   = REG_W_En_E && (Result_Src_Sel_E == 2'b01) &&
                       (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
    end

    // Prioritised stall/flush decode: reset > memory wait > mispredict > load-use.
    always_comb begin
        w_stall_f  = 1'b0;
        w_stall_d  = 1'b0;
        w_stall_e  = 1'b0;
        w_stall_m  = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        w_flush_w  = 1'b0;
        w_mp_flush = 1'b0;
        if (RST) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_mem_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_mispredict) begin
            // Fetch must not be held so the redirect target is taken.
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
            w_mp_flush = 1'b1;
        end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // Memory-wait FSM with timeout and sticky fault flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_wait_cnt <= '0;
                    if (MEM_Req_M && !MEM_Ready_M) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (MEM_Ready_M) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        // This wait cycle brings the count to MEM_TIMEOUT.
                        r_state     <= RUN;
                        r_wait_cnt  <= '0;
                        r_mem_fault <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_f && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_mp_flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign Stall_F      = w_stall_f;
    assign Stall_D      = w_stall_d;
    assign Stall_E      = w_stall_e;
    assign Stall_M      = w_stall_m;
    assign Flush_D      = w_flush_d;
    assign Flush_E      = w_flush_e;
    assign Flush_W      = w_flush_w;
    assign Mem_Fault    = r_mem_fault;
    assign Stall_Cycles = r_stall_cycles;
    assign Flush_Events = r_flush_events;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios followed by random traffic,
// checked against a behavioural model of the hazard rules.
module tb_hazard_controller;

    localparam int TIMEOUT = 4;
    localparam int CW      = 3;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          we;
    logic [1:0]    src;
    logic          valid, misp, req, rdy;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w;
    logic          mem_fault;
    logic [CW-1:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit m_waiting = 1'b0;
    int m_waited  = 0;
    bit m_fault   = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .CLK              (clk),
        .RST              (rst),
        .RS1_D            (rs1),
        .RS2_D            (rs2),
        .RD_E             (rd),
        .REG_W_En_E       (we),
        .Result_Src_Sel_E (src),
        .Valid_E          (valid),
        .Mispredict_E     (misp),
        .MEM_Req_M        (req),
        .MEM_Ready_M      (rdy),
        .Stall_F          (stall_f),
        .Stall_D          (stall_d),
        .Stall_E          (stall_e),
        .Stall_M          (stall_m),
        .Flush_D          (flush_d),
        .Flush_E          (flush_e),
        .Flush_W          (flush_w),
        .Mem_Fault        (mem_fault),
        .Stall_Cycles     (stall_cycles),
        .Flush_Events     (flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model at the negedge, then advance the model
    // with the upcoming posedge. Control vector order: SF SD SE SM FD FE FW.
    task automatic step();
        logic [6:0] exp_ctl;
        bit mem_busy, mp, lu;
        @(negedge clk);
        mem_busy = m_waiting ? !rdy : (req && !rdy);
        mp       = misp && valid;
        lu       = we && (src == 2'b01) && (rd != 0) && ((rd == rs1) || (rd == rs2));
        if (rst)           exp_ctl = 7'b0000_111;
        else if (mem_busy) exp_ctl = 7'b1111_001;
        else if (mp)       exp_ctl = 7'b0000_110;
        else if (lu)       exp_ctl = 7'b1100_010;
        else               exp_ctl = 7'b0000_000;
        chk("ctl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, exp_ctl);
        chk("fault", mem_fault, m_fault);
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("flush_events", flush_events, m_flushes);
        if (rst) begin
            m_waiting = 1'b0;
            m_waited  = 0;
            m_fault   = 1'b0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (exp_ctl[6] && m_stalls < CMAX) m_stalls++;
            if (!mem_busy && mp && m_flushes < CMAX) m_flushes++;
            if (!m_waiting) begin
                m_waiting = req && !rdy;
                m_waited  = 0;
            end else if (rdy) begin
                m_waiting = 1'b0;
                m_waited  = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_waiting = 1'b0;
                    m_waited  = 0;
                    m_fault   = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit r, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input bit w, input logic [1:0] s,
                       input bit v, input bit m, input bit q, input bit y);
        rst = r; rs1 = a; rs2 = b; rd = d; we = w; src = s;
        valid = v; misp = m; req = q; rdy = y;
        step();
    endtask

    initial begin
        // Reset held two cycles
        drv(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("post_rst_stalls", stall_cycles, 0);

        // Load-use on RS2, then RD=0 load must not stall
        drv(0, 3, 5, 5, 1, 2'b01, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("lu_stalls", stall_cycles, 1);
        drv(0, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0);
        chk("rd0_stalls", stall_cycles, 1);

        // Mispredict overriding load-use, then mispredict with Valid_E=0
        drv(0, 3, 5, 5, 1, 2'b01, 1, 1, 0, 0);
        chk("mp_flushes", flush_events, 1);
        drv(0, 1, 2, 7, 0, 2'b00, 0, 1, 0, 0);
        chk("mp_invalid_flushes", flush_events, 1);

        // Memory wait of three cycles with a mispredict pending throughout
        drv(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        repeat (3) drv(0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0);
        chk("memwait_no_flush", flush_events, 0);
        drv(0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 1);
        drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("memwait_stalls", stall_cycles, 3);
        chk("memwait_release_flush", flush_events, 1);

        // Timeout: ready never arrives
        repeat (TIMEOUT + 1) drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("timeout_fault", mem_fault, 1);
        repeat (3) drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        chk("fault_sticky", mem_fault, 1);
        drv(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("fault_cleared", mem_fault, 0);

        // Saturation: ten load-use stalls
        repeat (10) drv(0, 9, 4, 9, 1, 2'b01, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("stall_saturate", stall_cycles, CMAX);

        // Random traffic with small register ranges to make hazards frequent
        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 39) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom),
                2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), ($urandom_range(0, 9) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
